// File: rtl/i2s_rx_if.sv
// ---------------------------------------------------------------------------
// i2s_rx_if -- serial-side and frame-side signals of the I2S receiver.
//
// Signals
//   i2s_sclk      I2S bit clock (asynchronous to the system clock)
//   i2s_lrclk     I2S word select, 0 = left slot, 1 = right slot
//   i2s_sdata     I2S serial data, MSB first
//   sample_l      left sample of the held frame
//   sample_r      right sample of the held frame
//   sample_valid  held frame is valid
//   sample_ready  consumer accepts the held frame
//   overrun       sticky flag: a completed frame was dropped
//   overrun_clr   single-cycle pulse that clears overrun
//
// Modports
//   slave   the receiver itself
//   master  the environment: drives the I2S lines, consumes frames
// ---------------------------------------------------------------------------
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i2s_sclk;
    logic                  i2s_lrclk;
    logic                  i2s_sdata;
    logic [DATA_WIDTH-1:0] sample_l;
    logic [DATA_WIDTH-1:0] sample_r;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  overrun;
    logic                  overrun_clr;

    modport slave (
        input  i2s_sclk,
        input  i2s_lrclk,
        input  i2s_sdata,
        input  sample_ready,
        input  overrun_clr,
        output sample_l,
        output sample_r,
        output sample_valid,
        output overrun
    );

    modport master (
        output i2s_sclk,
        output i2s_lrclk,
        output i2s_sdata,
        output sample_ready,
        output overrun_clr,
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        input  overrun
    );
endinterface

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx -- I2S receiver with a one-frame output holding register.
//
// The three I2S lines are brought into the clk domain through 2-flop
// synchronizers. A rising edge of the synchronized bit clock is a bit event;
// all capture happens on bit events. Word-select changes mark slot
// boundaries, with the standard I2S one-bit delay: the bit sampled at the
// boundary still belongs to the slot that is ending.
//
// A completed {left, right} frame is staged for one cycle and then loaded
// into the output registers, which are drained by a valid/ready handshake.
// A frame that completes while the previous one is still unaccepted is
// dropped and sets the sticky overrun flag.
//
// Ports
//   clk   system clock, must run at least 8x the I2S bit clock
//   arst  asynchronous, active-high reset
//   bus   i2s_rx_if.slave (I2S lines, frame outputs, handshake, overrun)
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic     clk,
    input  logic     arst,
    i2s_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Write one serial bit into a slot word; position cnt counts from the MSB.
    // Positions past the end of the word leave the word unchanged.
    function automatic logic [DATA_WIDTH-1:0] put_bit(
        input logic [DATA_WIDTH-1:0] word,
        input logic [CNT_W-1:0]      cnt,
        input logic                  bit_val
    );
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == (DATA_WIDTH - 1 - int'(cnt))) begin
                res[i] = bit_val;
            end else begin
                res[i] = word[i];
            end
        end
        return res;
    endfunction

    // Synchronizer and edge-detect flops
    logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic lr_meta_r,   lr_sync_r;
    logic sd_meta_r,   sd_sync_r;

    // Capture state
    state_t                state_r,   state_s;
    logic [CNT_W-1:0]      bit_cnt_r, cnt_s;
    logic                  lr_held_r, lr_held_s;
    logic [DATA_WIDTH-1:0] left_r,    left_s;
    logic [DATA_WIDTH-1:0] right_r,   right_s;
    logic                  done_s;

    // Frame staging and output holding registers
    logic                  frame_done_r;
    logic [DATA_WIDTH-1:0] frame_l_r, frame_r_r;
    logic [DATA_WIDTH-1:0] out_l_r,   out_r_r;
    logic                  valid_r;
    logic                  overrun_r;

    // Decoded events
    logic                  bit_event_s;
    logic                  boundary_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [DATA_WIDTH-1:0] left_ins_s;
    logic [DATA_WIDTH-1:0] right_ins_s;
    logic                  transfer_s;

    // Two-flop synchronizers plus one extra sclk flop for edge detection.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            lr_meta_r   <= 1'b0;
            lr_sync_r   <= 1'b0;
            sd_meta_r   <= 1'b0;
            sd_sync_r   <= 1'b0;
        end else begin
            sclk_meta_r <= bus.i2s_sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            lr_meta_r   <= bus.i2s_lrclk;
            lr_sync_r   <= lr_meta_r;
            sd_meta_r   <= bus.i2s_sdata;
            sd_sync_r   <= sd_meta_r;
        end
    end

    // Bit-event / slot-boundary decode and the candidate slot words with the
    // current bit inserted.
    always_comb begin
        bit_event_s = sclk_sync_r & ~sclk_prev_r;
        boundary_s  = bit_event_s & (lr_sync_r ^ lr_held_r);
        if (bit_cnt_r == CNT_MAX) begin
            cnt_inc_s = bit_cnt_r;
        end else begin
            cnt_inc_s = bit_cnt_r + CNT_ONE;
        end
        left_ins_s  = put_bit(left_r,  bit_cnt_r, sd_sync_r);
        right_ins_s = put_bit(right_r, bit_cnt_r, sd_sync_r);
    end

    // Capture FSM next-state: slot tracking, bit placement, frame completion.
    always_comb begin
        state_s   = state_r;
        cnt_s     = bit_cnt_r;
        lr_held_s = lr_held_r;
        left_s    = left_r;
        right_s   = right_r;
        done_s    = 1'b0;
        if (bit_event_s) begin
            lr_held_s = lr_sync_r;
            // The bit lands in the slot that is open now; at a boundary that
            // is the slot being closed (one-bit delay).
            case (state_r)
                ST_LEFT: begin
                    left_s = left_ins_s;
                end
                ST_RIGHT: begin
                    right_s = right_ins_s;
                    if (bit_cnt_r == CNT_LAST) begin
                        done_s = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
                end
                default: begin
                    left_s = left_r;
                end
            endcase
            if (boundary_s) begin
                cnt_s = CNT_ZERO;
                case (state_r)
                    ST_SYNC: begin
                        if (!lr_sync_r) begin
                            state_s = ST_LEFT;
                            left_s  = WORD_ZERO;
                        end else begin
                            state_s = ST_SYNC;
                        end
                    end
                    ST_LEFT: begin
                        if (lr_sync_r) begin
                            state_s = ST_RIGHT;
                            right_s = WORD_ZERO;
                        end else begin
                            state_s = ST_LEFT;
                        end
                    end
                    ST_RIGHT: begin
                        if (!lr_sync_r) begin
                            state_s = ST_LEFT;
                            left_s  = WORD_ZERO;
                            // A right slot that never reached full width
                            // completes its frame here.
                            if (bit_cnt_r < CNT_MAX) begin
                                done_s = 1'b1;
                            end else begin
                                done_s = done_s;
                            end
                        end else begin
                            state_s = ST_RIGHT;
                        end
                    end
                    default: begin
                        state_s = ST_SYNC;
                    end
                endcase
            end else begin
                cnt_s = cnt_inc_s;
            end
        end else begin
            cnt_s = bit_cnt_r;
        end
    end

    // Capture FSM state register; a completed frame is staged for one cycle
    // because the left word may be cleared in the completing cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r      <= ST_SYNC;
            bit_cnt_r    <= CNT_ZERO;
            lr_held_r    <= 1'b0;
            left_r       <= WORD_ZERO;
            right_r      <= WORD_ZERO;
            frame_done_r <= 1'b0;
            frame_l_r    <= WORD_ZERO;
            frame_r_r    <= WORD_ZERO;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= cnt_s;
            lr_held_r    <= lr_held_s;
            left_r       <= left_s;
            right_r      <= right_s;
            frame_done_r <= done_s;
            if (done_s) begin
                frame_l_r <= left_r;
                frame_r_r <= right_ins_s;
            end else begin
                frame_l_r <= frame_l_r;
                frame_r_r <= frame_r_r;
            end
        end
    end

    assign transfer_s = valid_r & bus.sample_ready;

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_l_r   <= WORD_ZERO;
            out_r_r   <= WORD_ZERO;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (frame_done_r && (!valid_r || transfer_s)) begin
                out_l_r   <= frame_l_r;
                out_r_r   <= frame_r_r;
                valid_r   <= 1'b1;
                overrun_r <= overrun_r & ~bus.overrun_clr;
            end else if (frame_done_r) begin
                // Held frame not yet taken: drop the new one; set beats clear.
                overrun_r <= 1'b1;
            end else if (transfer_s) begin
                valid_r   <= 1'b0;
                overrun_r <= overrun_r & ~bus.overrun_clr;
            end else begin
                overrun_r <= overrun_r & ~bus.overrun_clr;
            end
        end
    end

    assign bus.sample_l     = out_l_r;
    assign bus.sample_r     = out_r_r;
    assign bus.sample_valid = valid_r;
    assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx -- self-checking bench for i2s_rx (DATA_WIDTH = 16).
// An I2S transmitter model drives frames with sclk at clk/8; expected frames
// are queued as they are driven and compared when the consumer accepts one.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            nbits;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;

    logic clk = 1'b0;
    logic arst;

    i2s_rx_if #(.DATA_WIDTH(DW)) bus ();

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int     pass_cnt = 0;
    int     total_cnt = 0;
    int     valid_cycles = 0;
    frame_t exp_q[$];
    logic   prev_d;
    vec_t   vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every accepted frame with the oldest expected one.
    always @(negedge clk) begin
        if (!arst && bus.sample_valid) begin
            valid_cycles++;
        end
        if (!arst && bus.sample_valid && bus.sample_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_frame: got 0x%0h/0x%0h, expected no frame (t=%0t)",
                         bus.sample_l, bus.sample_r, $time);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_l", 32'(bus.sample_l), 32'(f.l));
                check("frame_r", 32'(bus.sample_r), 32'(f.r));
            end
        end
    end

    // One sclk period (4 clk low, 4 clk high); sel 1/2 pulses sample_ready /
    // overrun_clr for the single clk cycle in which this bit's frame loads.
    task automatic drive_bit(input logic lr, input logic d, input int sel);
        bus.i2s_sclk  = 1'b0;
        bus.i2s_lrclk = lr;
        bus.i2s_sdata = d;
        repeat (4) @(posedge clk);
        #1;
        bus.i2s_sclk = 1'b1;
        if (sel != 0) begin
            repeat (3) @(posedge clk);
            #1;
            if (sel == 1) bus.sample_ready = 1'b1;
            else          bus.overrun_clr  = 1'b1;
            @(posedge clk);
            #1;
            bus.sample_ready = (sel == 1) ? 1'b0 : bus.sample_ready;
            bus.overrun_clr  = 1'b0;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    // One slot of nbits; each bit carries the previous slot position's data.
    task automatic drive_slot(input logic lr, input logic [DW-1:0] word, input int nbits, input int sel);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(lr, prev_d, (i == DW) ? sel : 0);
            prev_d = (i < DW) ? word[DW-1-i] : 1'b0;
        end
    endtask

    task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbits, input int sel);
        drive_slot(1'b0, l, nbits, 0);
        drive_slot(1'b1, r, nbits, sel);
    endtask

    task automatic do_reset();
        arst          = 1'b1;
        bus.i2s_sclk  = 1'b0;
        bus.i2s_lrclk = 1'b0;
        bus.i2s_sdata = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        arst   = 1'b0;
        prev_d = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{l: 16'h0000, r: 16'hFFFF, nbits: 16, exp_l: 16'h0000, exp_r: 16'hFFFF};
        vecs[1] = '{l: 16'h8001, r: 16'h7FFE, nbits: 16, exp_l: 16'h8001, exp_r: 16'h7FFE};
        vecs[2] = '{l: 16'hFFFF, r: 16'h0000, nbits: 24, exp_l: 16'hFFFF, exp_r: 16'h0000};
        vecs[3] = '{l: 16'hABCD, r: 16'h5A5F, nbits: 12, exp_l: 16'hABC0, exp_r: 16'h5A50};
        vecs[4] = '{l: 16'h1234, r: 16'h5678, nbits: 32, exp_l: 16'h1234, exp_r: 16'h5678};
        vecs[5] = '{l: 16'hC3A5, r: 16'h0F0F, nbits: 17, exp_l: 16'hC3A5, exp_r: 16'h0F0F};

        arst             = 1'b1;
        bus.i2s_sclk     = 1'b0;
        bus.i2s_lrclk    = 1'b0;
        bus.i2s_sdata    = 1'b0;
        bus.sample_ready = 1'b0;
        bus.overrun_clr  = 1'b0;
        prev_d           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid",   32'(bus.sample_valid), 32'h0);
        check("reset_l",       32'(bus.sample_l),     32'h0);
        check("reset_r",       32'(bus.sample_r),     32'h0);
        check("reset_overrun", 32'(bus.overrun),      32'h0);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Start mid right slot, then one 32-bit-slot frame.
        bus.sample_ready = 1'b1;
        drive_slot(1'b1, 16'hBEEF, 20, 0);
        valid_cycles = 0;
        exp_q.push_back('{l: 16'hA5C3, r: 16'h1234});
        drive_frame(16'hA5C3, 16'h1234, 32, 0);
        check("basic_valid_cycles", 32'(valid_cycles), 32'd1);
        check("basic_overrun",      32'(bus.overrun),  32'h0);

        // Table of frames with varied slot lengths, streamed back to back.
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back('{l: vecs[v].exp_l, r: vecs[v].exp_r});
            drive_frame(vecs[v].l, vecs[v].r, vecs[v].nbits, 0);
        end
        drive_slot(1'b0, 16'h0000, 3, 0);
        repeat (10) @(posedge clk);
        #1;
        check("table_queue_empty", 32'(exp_q.size()), 32'd0);

        // Consumer stalled for two frames: hold first, drop second.
        do_reset();
        bus.sample_ready = 1'b0;
        drive_slot(1'b1, 16'h0000, 8, 0);
        exp_q.push_back('{l: 16'h1111, r: 16'h2222});
        drive_frame(16'h1111, 16'h2222, 32, 0);
        drive_frame(16'h3333, 16'h4444, 32, 0);
        check("stall_valid",   32'(bus.sample_valid), 32'h1);
        check("stall_l",       32'(bus.sample_l),     32'h1111);
        check("stall_r",       32'(bus.sample_r),     32'h2222);
        check("stall_overrun", 32'(bus.overrun),      32'h1);
        bus.overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.overrun_clr = 1'b0;
        check("overrun_cleared", 32'(bus.overrun), 32'h0);
        // Clear pulse in the very cycle a drop sets overrun: set wins.
        drive_frame(16'h5555, 16'h6666, 32, 2);
        check("overrun_set_wins", 32'(bus.overrun), 32'h1);

        // Reset in the middle of a left slot.
        drive_slot(1'b0, 16'h7777, 8, 0);
        arst = 1'b1;
        #1;
        check("midreset_valid",   32'(bus.sample_valid), 32'h0);
        check("midreset_l",       32'(bus.sample_l),     32'h0);
        check("midreset_r",       32'(bus.sample_r),     32'h0);
        check("midreset_overrun", 32'(bus.overrun),      32'h0);
        do_reset();
        bus.sample_ready = 1'b1;
        drive_slot(1'b1, 16'hFFFF, 5, 0);
        exp_q.push_back('{l: 16'h9ABC, r: 16'hDEF0});
        drive_frame(16'h9ABC, 16'hDEF0, 32, 0);
        repeat (10) @(posedge clk);
        #1;
        check("postreset_queue_empty", 32'(exp_q.size()), 32'd0);

        // Accept the held frame exactly in the cycle the next one loads.
        do_reset();
        bus.sample_ready = 1'b0;
        drive_slot(1'b1, 16'h0000, 4, 0);
        exp_q.push_back('{l: 16'hCAFE, r: 16'hBEEF});
        drive_frame(16'hCAFE, 16'hBEEF, 32, 0);
        exp_q.push_back('{l: 16'h0102, r: 16'h0304});
        drive_frame(16'h0102, 16'h0304, 32, 1);
        check("sameload_valid",   32'(bus.sample_valid), 32'h1);
        check("sameload_l",       32'(bus.sample_l),     32'h0102);
        check("sameload_r",       32'(bus.sample_r),     32'h0304);
        check("sameload_overrun", 32'(bus.overrun),      32'h0);
        bus.sample_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("sameload_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sameload_drained",     32'(bus.sample_valid), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, bits captured per channel slot (range 8..32).
REQ-002 Port: clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 Port: arst  input  1  asynchronous, active-high reset.
REQ-004 Port: i2s_sclk  input  1  I2S bit clock, asynchronous to clk.
REQ-005 Port: i2s_lrclk  input  1  I2S word select: 0 = left slot, 1 = right slot.
REQ-006 Port: i2s_sdata  input  1  I2S serial data, MSB first.
REQ-007 Port: sample_l  output  DATA_WIDTH  left sample of the held frame.
REQ-008 Port: sample_r  output  DATA_WIDTH  right sample of the held frame.
REQ-009 Port: sample_valid  output  1  held frame is valid.
REQ-010 Port: sample_ready  input  1  consumer accepts the frame.
REQ-011 Port: overrun  output  1  sticky flag: a completed frame was dropped.
REQ-012 Port: overrun_clr  input  1  single-cycle pulse that clears overrun.

Function
REQ-013 i2s_sclk, i2s_lrclk and i2s_sdata SHALL each pass through a 2-flop synchronizer before use.
REQ-014 A bit event SHALL be the clk cycle in which synced sclk = 1 and its previous synced value = 0; all capture happens only on bit events.
REQ-015 Required clock ratio: clk frequency >= 8x sclk frequency. Behaviour below this ratio is undefined.
REQ-016 At each bit event, the block SHALL compare synced lrclk with the lrclk value held from the previous bit event; a difference is a slot boundary.
REQ-017 At a slot boundary, the bit counter SHALL reset to 0, and that event's sdata bit SHALL belong to the previous slot. This is the I2S one-bit delay.
REQ-018 Bit events 1..DATA_WIDTH after a boundary SHALL write sdata into slot bit DATA_WIDTH-count (MSB first).
REQ-019 Bits after the DATA_WIDTH-th bit in a slot SHALL be ignored.
REQ-020 The bit counter SHALL saturate at DATA_WIDTH and SHALL NOT wrap.
REQ-021 At a slot boundary, each slot SHALL be zero-cleared before capture starts, so that a short slot (fewer than DATA_WIDTH bits) yields its captured MSBs followed by zero LSBs.
REQ-022 FSM states SHALL be SYNC, LEFT and RIGHT. Reset state: SYNC.
REQ-023 SYNC -> LEFT on a 1->0 lrclk boundary; other boundaries keep SYNC; no data is captured in SYNC.
REQ-024 LEFT -> RIGHT on a 0->1 boundary.
REQ-025 RIGHT -> LEFT on a 1->0 boundary.
REQ-026 Frame completion SHALL be the bit event in which the right slot's DATA_WIDTH-th bit is captured, or a 1->0 boundary in RIGHT if the right slot is still short.
REQ-027 On frame completion, the {left, right} pair SHALL load into the output registers in the next clk cycle, and sample_valid SHALL be 1 from that cycle.
REQ-028 Completion latency: 1 clk cycle after the bit event (4 clk cycles after i2s_sclk rise is first sampled).
REQ-029 Handshake: a transfer occurs in a cycle with sample_valid = 1 and sample_ready = 1; sample_valid SHALL drop the next cycle unless a new frame loads.
REQ-030 sample_l and sample_r SHALL be stable while sample_valid = 1 and no transfer has occurred.
REQ-031 Load while sample_valid = 1 and sample_ready = 0: the new frame SHALL be dropped, the held frame kept, and overrun set.
REQ-032 Load in the same cycle as a transfer: the new frame SHALL load, sample_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-033 overrun_clr and an overrun set in the same cycle: set SHALL win.
REQ-034 Only frames whose left slot began in LEFT state after sync SHALL be emitted; the right slot seen before the first sync is never emitted.

Reset
REQ-035 While arst = 1: sample_valid = 0, sample_l = 0, sample_r = 0, overrun = 0, FSM = SYNC, bit counter = 0, synchronizers = 0, held lrclk = 0.
REQ-036 arst asserted mid-frame SHALL discard the partial frame and the held frame; after release, the block SHALL resynchronize per REQ-023.

Verification
REQ-037 Scenario: DATA_WIDTH=16, 32-bit slots, left=0xA5C3, right=0x1234, sample_ready=1 -> one frame sample_l=0xA5C3, sample_r=0x1234, sample_valid high exactly 1 cycle, overrun=0.
REQ-038 Scenario: capture starts with lrclk=1 mid right slot -> first emitted frame is the first complete left+right pair; no partial frame emitted.
REQ-039 Scenario: sample_ready=0 for two full frames (0x1111/0x2222, then 0x3333/0x4444) -> outputs hold 0x1111/0x2222, overrun=1; overrun_clr pulse -> overrun=0.
REQ-040 Scenario: 12-bit slots with DATA_WIDTH=16, left bits 0xABC -> sample_l=0xABC0; right=0x5A5 -> sample_r=0x5A50.
REQ-041 Scenario: sample_ready pulsed in the exact cycle the next frame loads -> the new frame is presented, sample_valid stays 1, overrun=0.
REQ-042 Scenario: arst pulsed during the left slot -> all outputs 0 immediately; after release, the next full frame is received correctly.
